// File: rtl/ascon_ctrl_fsm_if.sv
// Handshake and datapath-control bundle between an Ascon AEAD sequencer and its user.
// The master issues requests and blocks; the slave is the control FSM.
interface ascon_ctrl_fsm_if;
    logic       start_i;
    logic       data_valid_i;
    logic       last_block_i;
    logic       enable_o;
    logic       selectionp_o;
    logic       bypass_begin_o;
    logic       bypass_end_o;
    logic       mode_init_data_o;
    logic       mode_int_ext_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic [3:0] round_o;
    logic       data_ready_o;
    logic       busy_o;
    logic       done_o;

    modport master (
        output start_i, data_valid_i, last_block_i,
        input  enable_o, selectionp_o, bypass_begin_o, bypass_end_o,
        input  mode_init_data_o, mode_int_ext_o, en_cipher_o, en_tag_o,
        input  round_o, data_ready_o, busy_o, done_o
    );

    modport slave (
        input  start_i, data_valid_i, last_block_i,
        output enable_o, selectionp_o, bypass_begin_o, bypass_end_o,
        output mode_init_data_o, mode_int_ext_o, en_cipher_o, en_tag_o,
        output round_o, data_ready_o, busy_o, done_o
    );
endinterface

// File: rtl/ascon_ctrl_fsm.sv
// Moore sequencer for an Ascon AEAD datapath: p12 init, p6 per AD/PT block, p12 finalization.
// Outputs decode from state and round counter only.
module ascon_ctrl_fsm (
    input logic              clock_i,
    input logic              resetb_i,
    ascon_ctrl_fsm_if.slave  ctrl_if
);

    typedef enum logic [2:0] {
        S_IDLE, S_INIT, S_WAIT_AD, S_AD, S_WAIT_PT, S_PT, S_FIN, S_DONE
    } state_e;

    localparam logic [3:0] ROUND_P12  = 4'd0;
    localparam logic [3:0] ROUND_P6   = 4'd6;
    localparam logic [3:0] ROUND_LAST = 4'd11;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic       last_round;

    assign last_round = (round_q == ROUND_LAST);

    always_ff @(posedge clock_i) begin
        // NOTE: non-blocking so state and round both update from pre-edge values.
        if (resetb_i) begin
            state_q <= S_IDLE;
            round_q <= ROUND_P12;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
        end
    end

    // The counter parks at 11 while waiting, so round_o stays stable during stalls.
    always_comb begin
        // NOTE: defaults first so every path assigns every signal and no latch is inferred.
        state_d = state_q;
        round_d = round_q;
        case (state_q)
            S_IDLE: begin
                if (ctrl_if.start_i) begin
                    state_d = S_INIT;
                    round_d = ROUND_P12;
                end
            end
            S_INIT: begin
                if (last_round) state_d = S_WAIT_AD;
                else            round_d = round_q + 4'd1;
            end
            S_WAIT_AD: begin
                if (ctrl_if.data_valid_i) begin
                    state_d = S_AD;
                    round_d = ROUND_P6;
                end
            end
            S_AD: begin
                if (last_round) state_d = S_WAIT_PT;
                else            round_d = round_q + 4'd1;
            end
            S_WAIT_PT: begin
                if (ctrl_if.data_valid_i) begin
                    if (ctrl_if.last_block_i) begin
                        state_d = S_FIN;
                        round_d = ROUND_P12;
                    end else begin
                        state_d = S_PT;
                        round_d = ROUND_P6;
                    end
                end
            end
            S_PT: begin
                if (last_round) state_d = S_WAIT_PT;
                else            round_d = round_q + 4'd1;
            end
            S_FIN: begin
                if (last_round) state_d = S_DONE;
                else            round_d = round_q + 4'd1;
            end
            S_DONE: begin
                state_d = S_IDLE;
                round_d = ROUND_P12;
            end
            default: begin
                state_d = S_IDLE;
                round_d = ROUND_P12;
            end
        endcase
    end

    logic enable, selectionp, bypass_begin, bypass_end;
    logic mode_init_data, mode_int_ext, en_cipher, en_tag;
    logic data_ready, done;

    always_comb begin
        enable         = 1'b0;
        selectionp     = 1'b1;
        bypass_begin   = 1'b1;
        bypass_end     = 1'b1;
        mode_init_data = 1'b1;
        mode_int_ext   = 1'b0;
        en_cipher      = 1'b0;
        en_tag         = 1'b0;
        data_ready     = 1'b0;
        done           = 1'b0;
        case (state_q)
            S_IDLE: selectionp = 1'b0;
            S_INIT: begin
                enable = 1'b1;
                if (round_q == ROUND_P12) selectionp = 1'b0;
                if (last_round) begin
                    bypass_end   = 1'b0;
                    mode_int_ext = 1'b1;
                end
            end
            S_WAIT_AD, S_WAIT_PT: data_ready = 1'b1;
            S_AD: begin
                enable = 1'b1;
                if (round_q == ROUND_P6) bypass_begin = 1'b0;
                if (last_round)          bypass_end   = 1'b0;
            end
            S_PT: begin
                enable = 1'b1;
                if (round_q == ROUND_P6) begin
                    bypass_begin = 1'b0;
                    en_cipher    = 1'b1;
                end
            end
            S_FIN: begin
                enable = 1'b1;
                // Round 0 absorbs the last block then XORs the key in ahead of p12.
                if (round_q == ROUND_P12) begin
                    bypass_begin   = 1'b0;
                    mode_init_data = 1'b0;
                    en_cipher      = 1'b1;
                end
                if (last_round) begin
                    bypass_end   = 1'b0;
                    mode_int_ext = 1'b1;
                    en_tag       = 1'b1;
                end
            end
            S_DONE: done = 1'b1;
            default: ;
        endcase
    end

    assign ctrl_if.enable_o         = enable;
    assign ctrl_if.selectionp_o     = selectionp;
    assign ctrl_if.bypass_begin_o   = bypass_begin;
    assign ctrl_if.bypass_end_o     = bypass_end;
    assign ctrl_if.mode_init_data_o = mode_init_data;
    assign ctrl_if.mode_int_ext_o   = mode_int_ext;
    assign ctrl_if.en_cipher_o      = en_cipher;
    assign ctrl_if.en_tag_o         = en_tag;
    assign ctrl_if.round_o          = (state_q == S_IDLE) ? ROUND_P12 : round_q;
    assign ctrl_if.data_ready_o     = data_ready;
    assign ctrl_if.busy_o           = (state_q != S_IDLE);
    assign ctrl_if.done_o           = done;

endmodule

// File: tb/tb_ascon_ctrl_fsm.sv
// Directed bench for ascon_ctrl_fsm: reset, init, AD+last block, multi-block PT,
// stall with ignored starts, and reset in the middle of init.
module tb_ascon_ctrl_fsm;

    logic clock_i;
    logic resetb_i;
    ascon_ctrl_fsm_if bus ();

    ascon_ctrl_fsm dut (
        .clock_i  (clock_i),
        .resetb_i (resetb_i),
        .ctrl_if  (bus)
    );

    initial clock_i = 1'b0;
    always #5 clock_i = ~clock_i;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Pulse counters sampled mid-cycle.
    int cipher_cnt = 0;
    int tag_cnt    = 0;
    int both_cnt   = 0;
    always @(negedge clock_i) begin
        if (bus.en_cipher_o)                cipher_cnt++;
        if (bus.en_tag_o)                   tag_cnt++;
        if (bus.en_cipher_o && bus.en_tag_o) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0d, required %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock_i);
        #1;
        cyc++;
    endtask

    task automatic run_init();
        for (int r = 0; r < 12; r++) begin
            check("init.round",  bus.round_o, r);
            check("init.enable", bus.enable_o, 1);
            check("init.selp",   bus.selectionp_o, (r == 0) ? 0 : 1);
            check("init.bend",   bus.bypass_end_o, (r == 11) ? 0 : 1);
            check("init.keyx",   bus.mode_int_ext_o, (r == 11) ? 1 : 0);
            tick();
        end
    endtask

    task automatic run_p6(input bit is_pt);
        for (int r = 6; r < 12; r++) begin
            check("p6.round",  bus.round_o, r);
            check("p6.enable", bus.enable_o, 1);
            check("p6.bbegin", bus.bypass_begin_o, (r == 6) ? 0 : 1);
            check("p6.bend",   bus.bypass_end_o, (!is_pt && r == 11) ? 0 : 1);
            check("p6.cipher", bus.en_cipher_o, (is_pt && r == 6) ? 1 : 0);
            check("p6.intext", bus.mode_int_ext_o, 0);
            tick();
        end
    endtask

    task automatic run_fin();
        for (int r = 0; r < 12; r++) begin
            check("fin.round",  bus.round_o, r);
            check("fin.enable", bus.enable_o, 1);
            check("fin.bbegin", bus.bypass_begin_o, (r == 0) ? 0 : 1);
            check("fin.mdata",  bus.mode_init_data_o, (r == 0) ? 0 : 1);
            check("fin.cipher", bus.en_cipher_o, (r == 0) ? 1 : 0);
            check("fin.tag",    bus.en_tag_o, (r == 11) ? 1 : 0);
            check("fin.bend",   bus.bypass_end_o, (r == 11) ? 0 : 1);
            check("fin.intext", bus.mode_int_ext_o, (r == 11) ? 1 : 0);
            tick();
        end
    endtask

    task automatic check_wait(input string tag);
        check({tag, ".ready"},  bus.data_ready_o, 1);
        check({tag, ".enable"}, bus.enable_o, 0);
        check({tag, ".busy"},   bus.busy_o, 1);
    endtask

    task automatic check_done();
        check("done.done",   bus.done_o, 1);
        check("done.enable", bus.enable_o, 0);
        check("done.busy",   bus.busy_o, 1);
        tick();
        check("idle.done",   bus.done_o, 0);
        check("idle.busy",   bus.busy_o, 0);
        check("idle.selp",   bus.selectionp_o, 0);
        check("idle.round",  bus.round_o, 0);
    endtask

    int c0, cipher0, tag0;

    initial begin
        bus.start_i      = 1'b0;
        bus.data_valid_i = 1'b0;
        bus.last_block_i = 1'b0;
        resetb_i         = 1'b1;

        // Reset then idle
        tick();
        tick();
        resetb_i = 1'b0;
        check("rst.enable", bus.enable_o, 0);
        check("rst.selp",   bus.selectionp_o, 0);
        check("rst.bbegin", bus.bypass_begin_o, 1);
        check("rst.bend",   bus.bypass_end_o, 1);
        check("rst.round",  bus.round_o, 0);
        check("rst.busy",   bus.busy_o, 0);
        check("rst.ready",  bus.data_ready_o, 0);
        tick();
        check("idle.hold",  bus.busy_o, 0);

        // One AD block and a last PT block, valid/last held high throughout
        bus.data_valid_i = 1'b1;
        bus.last_block_i = 1'b1;
        bus.start_i      = 1'b1;
        c0 = cyc;
        tick();
        bus.start_i = 1'b0;
        run_init();
        check_wait("wad");
        tick();
        run_p6(1'b0);
        check_wait("wpt");
        tick();
        run_fin();
        check("s2d.cycles", cyc - c0, 33);
        check_done();
        bus.data_valid_i = 1'b0;
        bus.last_block_i = 1'b0;

        // Three PT blocks, last on the third
        cipher0 = cipher_cnt;
        tag0    = tag_cnt;
        bus.data_valid_i = 1'b1;
        bus.start_i      = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_init();
        check_wait("m.wad");
        tick();
        run_p6(1'b0);
        check_wait("m.wpt1");
        tick();
        run_p6(1'b1);
        check_wait("m.wpt2");
        tick();
        run_p6(1'b1);
        check_wait("m.wpt3");
        bus.last_block_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        bus.last_block_i = 1'b0;
        run_fin();
        check_done();
        check("m.cipher_pulses", cipher_cnt - cipher0, 3);
        check("m.tag_pulses",    tag_cnt - tag0, 1);

        // Stall in WAIT_PT with start pulses that must be ignored
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        run_init();
        bus.data_valid_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        run_p6(1'b0);
        for (int i = 0; i < 20; i++) begin
            bus.start_i = (i % 3 == 0);
            check_wait("stall");
            check("stall.round", bus.round_o, 11);
            tick();
        end
        bus.start_i = 1'b0;
        check_wait("stall.end");
        bus.data_valid_i = 1'b1;
        bus.last_block_i = 1'b1;
        tick();
        bus.data_valid_i = 1'b0;
        bus.last_block_i = 1'b0;
        run_fin();
        check_done();

        // Reset at INIT round 5, asserted together with start and data_valid
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        check("mid.round5", bus.round_o, 5);
        resetb_i         = 1'b1;
        bus.start_i      = 1'b1;
        bus.data_valid_i = 1'b1;
        tick();
        resetb_i         = 1'b0;
        bus.start_i      = 1'b0;
        bus.data_valid_i = 1'b0;
        check("mid.busy",   bus.busy_o, 0);
        check("mid.round",  bus.round_o, 0);
        check("mid.enable", bus.enable_o, 0);
        check("mid.selp",   bus.selectionp_o, 0);
        bus.start_i = 1'b1;
        tick();
        bus.start_i = 1'b0;
        check("re.round",  bus.round_o, 0);
        check("re.selp",   bus.selectionp_o, 0);
        check("re.enable", bus.enable_o, 1);
        check("re.busy",   bus.busy_o, 1);
        tick();
        check("re.round1", bus.round_o, 1);

        check("strobe.overlap", both_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
